ber_checker_pam4: RTL and testbench
===================================

Name: ber_checker_pam4

Overview:
- Downstream of slicer_pam4: consumes the slicer's 2-bit Gray symbol stream and compares it against the transmitted reference symbol stream.
- Automatically searches for the end-to-end channel/FIR/slicer latency, then locks.
- Once locked, accumulates symbol and bit-error counts for BER measurement.
- Detects loss of lock and restarts the search.

Parameters:
- MAX_DELAY, 32, number of candidate delays searched (0..MAX_DELAY-1); reference delay-line depth.
- NB_DLY, 5, width of delay index, clog2(MAX_DELAY).
- WINDOW, 256, accepted symbols per evaluation window.
- NB_WIN, 9, width of window counters (holds WINDOW).
- LOCK_THR, 0, maximum bit errors in a window for SEARCH→LOCKED.
- LOSS_THR, 32, bit errors in a window above which LOCKED→SEARCH.
- NB_CNT, 32, width of statistics counters.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  block enable; when low, all state holds.
- i_valid  in  1  symbol strobe; accept = i_enable & i_valid.
- i_ref_gray  in  2  transmitted reference Gray symbol, presented on accept.
- i_rx_gray  in  2  received Gray symbol from slicer_pam4, presented on accept.
- i_clear_stats  in  1  synchronous clear of statistics counters.
- o_locked  out  1  high in LOCKED state.
- o_delay  out  NB_DLY  current candidate/locked delay.
- o_sym_count  out  NB_CNT  symbols compared while locked.
- o_bit_errors  out  NB_CNT  bit errors counted while locked.

Behaviour:
- Reset (i_reset=1 at posedge):
  - State SEARCH; o_delay=0; o_locked=0.
  - o_sym_count=0; o_bit_errors=0.
  - Delay line, fill counter and window counters cleared.
  - Reset mid-lock discards everything.
- Delay line:
  - On accept, i_ref_gray shifts into a MAX_DELAY-deep register array; a fill counter saturates at MAX_DELAY.
  - Tap d is the reference accepted d symbols earlier; d=0 is the current i_ref_gray (combinational).
  - A comparison is valid only when fill > d (including the current symbol).
  - Invalid comparisons are ignored: no window advance, no counts.
- Error metric: bit errors = popcount(i_rx_gray ^ tap[o_delay]), range 0..2.
- SEARCH:
  - Each valid compare increments win_cnt and adds to win_err.
  - On the WINDOW-th compare:
    - If win_err (including this symbol) <= LOCK_THR, go to LOCKED next cycle.
    - Else o_delay = (o_delay+1) mod MAX_DELAY, wrapping MAX_DELAY-1→0.
  - Window counters reset on every window end.
- LOCKED:
  - Each valid compare does o_sym_count += 1 and o_bit_errors += errors.
  - Both counters saturate at all-ones and hold.
  - Window monitoring continues; at a window end with win_err > LOSS_THR:
    - Go to SEARCH; o_delay advances mod MAX_DELAY.
    - Statistics freeze (retained, no longer incremented).
- Latency: o_locked and o_delay update on the clock edge that accepts the final symbol of a window, so they are visible the following cycle.
- i_clear_stats:
  - Zeroes o_sym_count and o_bit_errors; takes priority over a simultaneous increment (that symbol is not counted).
  - Does not affect state, delay or window counters.
- i_enable=0: no state changes, regardless of i_valid.
- Gaps in i_valid do not alter results; only the accepted-symbol order matters.

Test Plan:
- rx = ref delayed by 2 accepted symbols, random PRBS ref, no errors:
  - Windows at d=0 and d=1 fail.
  - o_locked=1 with o_delay=2 after the third window completes, about 3*256 accepted symbols plus fill.
  - Thereafter o_sym_count increments by 1 per accept and o_bit_errors=0.
- Locked at delay 2, inject one rx corruption 2'b00→2'b11 → o_bit_errors=2; one corruption 00→01 → o_bit_errors=3; o_locked stays 1.
- rx uncorrelated random:
  - o_locked never asserts.
  - o_delay steps 0,1,…,31,0 once per 256 compares.
  - Statistics stay 0.
- Locked, then rx switched to random:
  - o_locked drops at the next window end.
  - o_delay becomes 3.
  - o_sym_count/o_bit_errors freeze at their values.
  - i_clear_stats pulse → both 0.
- i_valid toggling 1-of-3 cycles with delay 5 → locks at o_delay=5, same counts as the continuous-valid run; assert i_reset while locked → all outputs 0 next cycle.
- NB_CNT=8 override, locked error-free run of 300 symbols → o_sym_count saturates at 255 and holds.

Source files
------------

// File: rtl/ber_checker_pam4.sv
// PAM4 BER checker: searches for the rx/ref alignment delay, locks on a clean window,
// then accumulates symbol and bit-error counts until a bad window forces a new search.
module ber_checker_pam4 #(
  parameter int MAX_DELAY = 32,
  parameter int NB_DLY    = 5,
  parameter int WINDOW    = 256,
  parameter int NB_WIN    = 9,
  parameter int LOCK_THR  = 0,
  parameter int LOSS_THR  = 32,
  parameter int NB_CNT    = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [1:0]        i_ref_gray,
  input  logic [1:0]        i_rx_gray,
  input  logic              i_clear_stats,
  output logic              o_locked,
  output logic [NB_DLY-1:0] o_delay,
  output logic [NB_CNT-1:0] o_sym_count,
  output logic [NB_CNT-1:0] o_bit_errors
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state, state_next;
  logic [NB_DLY-1:0] delay, delay_next;
  // Tap 0 is the live reference input, so only MAX_DELAY-1 stored symbols are needed.
  logic [1:0]        dl [MAX_DELAY-1];
  logic [NB_DLY:0]   fill;
  logic [NB_WIN-1:0] win_cnt;
  logic [NB_WIN:0]   win_err, win_err_sum;
  logic [NB_CNT-1:0] sym_count, bit_errors;
  logic [NB_CNT:0]   err_acc;

  logic       accept, cmp_valid, win_end;
  logic [1:0] tap, diff, errs;

  assign accept = i_enable & i_valid;

  always_comb begin
    tap = i_ref_gray;
    if (delay != '0) tap = dl[delay - NB_DLY'(1)];
  end

  // fill counts earlier symbols, so fill >= d means tap d already holds real data.
  assign cmp_valid   = accept && (fill >= {1'b0, delay});
  assign diff        = i_rx_gray ^ tap;
  assign errs        = {1'b0, diff[1]} + {1'b0, diff[0]};
  assign win_err_sum = win_err + (NB_WIN+1)'(errs);
  assign win_end     = cmp_valid && (win_cnt == NB_WIN'(WINDOW - 1));
  assign err_acc     = {1'b0, bit_errors} + (NB_CNT+1)'(errs);

  always_comb begin
    state_next = state;
    delay_next = delay;
    if (win_end) begin
      case (state)
        SEARCH: begin
          if (win_err_sum <= (NB_WIN+1)'(LOCK_THR)) state_next = LOCKED;
          else delay_next = (delay == NB_DLY'(MAX_DELAY - 1)) ? '0 : delay + NB_DLY'(1);
        end
        LOCKED: begin
          if (win_err_sum > (NB_WIN+1)'(LOSS_THR)) begin
            state_next = SEARCH;
            delay_next = (delay == NB_DLY'(MAX_DELAY - 1)) ? '0 : delay + NB_DLY'(1);
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= SEARCH;
      delay      <= '0;
      fill       <= '0;
      win_cnt    <= '0;
      win_err    <= '0;
      sym_count  <= '0;
      bit_errors <= '0;
      for (int i = 0; i < MAX_DELAY - 1; i++) dl[i] <= '0;
    end else if (i_enable) begin
      state <= state_next;
      delay <= delay_next;
      if (accept) begin
        dl[0] <= i_ref_gray;
        for (int i = 1; i < MAX_DELAY - 1; i++) dl[i] <= dl[i-1];
        if (fill != (NB_DLY+1)'(MAX_DELAY)) fill <= fill + (NB_DLY+1)'(1);
      end
      if (win_end) begin
        win_cnt <= '0;
        win_err <= '0;
      end else if (cmp_valid) begin
        win_cnt <= win_cnt + NB_WIN'(1);
        win_err <= win_err_sum;
      end
      // Clear wins over a same-cycle increment; counters saturate at all-ones.
      if (i_clear_stats) begin
        sym_count  <= '0;
        bit_errors <= '0;
      end else if (cmp_valid && state == LOCKED) begin
        if (sym_count != '1) sym_count <= sym_count + NB_CNT'(1);
        bit_errors <= err_acc[NB_CNT] ? '1 : err_acc[NB_CNT-1:0];
      end
    end
  end

  assign o_locked     = (state == LOCKED);
  assign o_delay      = delay;
  assign o_sym_count  = sym_count;
  assign o_bit_errors = bit_errors;

endmodule

// File: tb/tb_ber_checker_pam4.sv
// Bench for ber_checker_pam4: directed alignment/lock/loss scenarios with a queued
// expectation scoreboard drained by a negedge monitor.
module tb_ber_checker_pam4;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_valid, i_clear_stats;
  logic [1:0]  i_ref_gray, i_rx_gray;
  logic        o_locked, o_locked8;
  logic [4:0]  o_delay, o_delay8;
  logic [31:0] o_sym_count, o_bit_errors;
  logic [7:0]  o_sym_count8, o_bit_errors8;

  always #5 clk = ~clk;

  ber_checker_pam4 dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_ref_gray(i_ref_gray), .i_rx_gray(i_rx_gray), .i_clear_stats(i_clear_stats),
    .o_locked(o_locked), .o_delay(o_delay), .o_sym_count(o_sym_count),
    .o_bit_errors(o_bit_errors)
  );

  ber_checker_pam4 #(.NB_CNT(8)) dut8 (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_ref_gray(i_ref_gray), .i_rx_gray(i_rx_gray), .i_clear_stats(i_clear_stats),
    .o_locked(o_locked8), .o_delay(o_delay8), .o_sym_count(o_sym_count8),
    .o_bit_errors(o_bit_errors8)
  );

  localparam int K_LOCK = 0, K_DLY = 1, K_SYM = 2, K_ERR = 3, K_SYM8 = 4, K_ERR8 = 5;

  int          kind_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          passed = 0;
  int          k = 0;
  logic [1:0]  hist [0:16383];

  // ---------------- scoreboard monitor ----------------
  int          mon_kind;
  logic [31:0] mon_exp, mon_act;
  string       mon_name;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_kind = kind_q.pop_front();
      mon_exp  = exp_q.pop_front();
      case (mon_kind)
        K_LOCK:  begin mon_act = {31'd0, o_locked};     mon_name = "locked";      end
        K_DLY:   begin mon_act = {27'd0, o_delay};      mon_name = "delay";       end
        K_SYM:   begin mon_act = o_sym_count;           mon_name = "sym_count";   end
        K_ERR:   begin mon_act = o_bit_errors;          mon_name = "bit_errors";  end
        K_SYM8:  begin mon_act = {24'd0, o_sym_count8}; mon_name = "sym_count8";  end
        default: begin mon_act = {24'd0, o_bit_errors8}; mon_name = "bit_errors8"; end
      endcase
      checks++;
      if (mon_act !== mon_exp)
        $display("FAIL %s actual=%0d expected=%0d (t=%0t)", mon_name, mon_act, mon_exp, $time);
      else
        passed++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_out(input int kind, input logic [31:0] v);
    kind_q.push_back(kind);
    exp_q.push_back(v);
  endtask

  task automatic expect_all(input logic lk, input int dly, input int sym, input int err);
    expect_out(K_LOCK, {31'd0, lk});
    expect_out(K_DLY, dly);
    expect_out(K_SYM, sym);
    expect_out(K_ERR, err);
  endtask

  function automatic int pc2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic do_reset();
    i_reset = 1'b1;
    i_enable = 1'b0;
    i_valid = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    k = 0;
  endtask

  task automatic accept(input logic [1:0] r, input logic [1:0] x);
    i_enable = 1'b1;
    i_valid = 1'b1;
    i_ref_gray = r;
    i_rx_gray = x;
    hist[k] = r;
    @(posedge clk); #1;
    i_valid = 1'b0;
    k++;
  endtask

  // rx is the reference from dly accepts earlier, optionally with bits flipped.
  task automatic send_delayed(input int dly, input logic [1:0] flip);
    logic [1:0] r, x;
    r = 2'($urandom_range(0, 3));
    x = (k >= dly) ? (hist[k-dly] ^ flip) : 2'b00;
    accept(r, x);
  endtask

  task automatic send_random();
    accept(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
  endtask

  // One idle cycle, then one cycle with valid high but the block disabled.
  task automatic gap();
    i_enable = 1'b1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    i_enable = 1'b0;
    i_valid = 1'b1;
    i_ref_gray = 2'($urandom_range(0, 3));
    i_rx_gray = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_enable = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int model_err;
  logic [1:0] r, x;

  initial begin
    i_reset = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_clear_stats = 1'b0;
    i_ref_gray = 2'b00; i_rx_gray = 2'b00;

    // A: rx = ref delayed by 2, error free
    do_reset();
    expect_all(1'b0, 0, 0, 0);
    expect_out(K_SYM8, 0);
    repeat (256) send_delayed(2, 2'b00);
    expect_out(K_LOCK, 0); expect_out(K_DLY, 1);
    repeat (256) send_delayed(2, 2'b00);
    expect_out(K_LOCK, 0); expect_out(K_DLY, 2);
    repeat (255) send_delayed(2, 2'b00);
    expect_out(K_LOCK, 0); expect_out(K_DLY, 2);
    send_delayed(2, 2'b00);
    expect_all(1'b1, 2, 0, 0);
    repeat (100) send_delayed(2, 2'b00);
    expect_all(1'b1, 2, 100, 0);
    send_delayed(2, 2'b11);
    expect_all(1'b1, 2, 101, 2);
    send_delayed(2, 2'b01);
    expect_all(1'b1, 2, 102, 3);
    repeat (198) send_delayed(2, 2'b00);
    expect_all(1'b1, 2, 300, 3);
    expect_out(K_SYM8, 255); expect_out(K_ERR8, 3);

    // B: rx goes random; lock lost at the window ending on the 512th locked symbol
    model_err = 3;
    for (int m = 300; m < 512; m++) begin
      r = 2'($urandom_range(0, 3));
      x = 2'($urandom_range(0, 3));
      model_err += pc2(x ^ hist[k-2]);
      accept(r, x);
      if (m == 510) expect_out(K_LOCK, 1);
    end
    expect_all(1'b0, 3, 512, model_err);
    expect_out(K_SYM8, 255);
    expect_out(K_ERR8, (model_err > 255) ? 255 : model_err);
    repeat (10) send_random();
    expect_all(1'b0, 3, 512, model_err);
    i_clear_stats = 1'b1;
    @(posedge clk); #1;
    i_clear_stats = 1'b0;
    expect_all(1'b0, 3, 0, 0);
    expect_out(K_SYM8, 0); expect_out(K_ERR8, 0);

    // C: uncorrelated rx, delay sweeps through all candidates and wraps
    do_reset();
    for (int j = 1; j <= 33; j++) begin
      repeat (256) send_random();
      expect_all(1'b0, j % 32, 0, 0);
    end

    // D: delay 5 with sparse valid and disabled cycles, then reset while locked
    do_reset();
    expect_all(1'b0, 0, 0, 0);
    repeat (1280) begin gap(); send_delayed(5, 2'b00); end
    expect_out(K_LOCK, 0); expect_out(K_DLY, 5);
    repeat (255) begin gap(); send_delayed(5, 2'b00); end
    expect_out(K_LOCK, 0); expect_out(K_DLY, 5);
    gap(); send_delayed(5, 2'b00);
    expect_all(1'b1, 5, 0, 0);
    repeat (50) begin gap(); send_delayed(5, 2'b00); end
    expect_all(1'b1, 5, 50, 0);
    gap();
    expect_all(1'b1, 5, 50, 0);
    do_reset();
    expect_all(1'b0, 0, 0, 0);
    expect_out(K_SYM8, 0); expect_out(K_ERR8, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
